// File: rtl/uart_tx_scheduler.sv
// Purpose : two-source (ALU word / RF byte) round-robin front end feeding a UART transmitter byte by byte.
// Latency : VLD seen in IDLE -> ACK same cycle, TX_DATA_VALID the next cycle; ALU words go LSB byte first.
// Backpr. : grants wait while TX_BUSY=1; each byte waits for Busy to rise and fall, re-strobing if it never rises.
// Ports   : i_clk/i_rst (async, active-high) | i_alu_vld/i_alu_out/o_alu_ack, i_rf_vld/i_rf_data/o_rf_ack (requesters)
//           i_tx_busy, o_tx_p_data, o_tx_data_valid (transmitter side) | o_sched_busy, o_grant_alu (status)
module uart_tx_scheduler #(
   parameter int DATA_WIDTH    = 8,
   parameter int ALU_WIDTH     = 16,
   parameter int START_TIMEOUT = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_alu_vld,
   input  logic [ALU_WIDTH-1:0]  i_alu_out,
   output logic                  o_alu_ack,
   input  logic                  i_rf_vld,
   input  logic [DATA_WIDTH-1:0] i_rf_data,
   output logic                  o_rf_ack,
   input  logic                  i_tx_busy,
   output logic [DATA_WIDTH-1:0] o_tx_p_data,
   output logic                  o_tx_data_valid,
   output logic                  o_sched_busy,
   output logic                  o_grant_alu
);

   localparam int NB = ALU_WIDTH / DATA_WIDTH;
   localparam int CW = $clog2(NB + 1);
   localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
   localparam logic [CW-1:0] NB_CNT  = CW'(NB);
   localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_START, S_WAIT_END} state_t;

   state_t               r_state, w_state_nxt;
   logic [ALU_WIDTH-1:0] r_hold, w_hold_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [TW-1:0]        r_to_cnt, w_to_nxt;
   logic                 r_last_alu, w_last_alu_nxt;   // 1 = ALU was served last, so RF wins a tie
   logic                 r_sched_busy, w_sched_busy_nxt;
   logic                 r_grant_alu, w_grant_alu_nxt;
   logic [DATA_WIDTH-1:0] r_tx_p_data;
   logic                 r_tx_dv;
   logic                 w_alu_ack, w_rf_ack;
   logic [ALU_WIDTH-1:0] w_rf_ext;

   assign w_rf_ext = ALU_WIDTH'(i_rf_data);

   always_comb begin
      w_state_nxt      = r_state;
      w_hold_nxt       = r_hold;
      w_cnt_nxt        = r_cnt;
      w_to_nxt         = r_to_cnt;
      w_last_alu_nxt   = r_last_alu;
      w_sched_busy_nxt = r_sched_busy;
      w_grant_alu_nxt  = r_grant_alu;
      w_alu_ack        = 1'b0;
      w_rf_ack         = 1'b0;
      case (r_state)
         S_IDLE: begin
            // A frame still on the line (e.g. after a reset mid-transfer) blocks new grants.
            if (!i_tx_busy && (i_alu_vld || i_rf_vld)) begin
               w_state_nxt      = S_LOAD;
               w_sched_busy_nxt = 1'b1;
               if (i_alu_vld && (!i_rf_vld || !r_last_alu)) begin
                  w_alu_ack       = 1'b1;
                  w_hold_nxt      = i_alu_out;
                  w_cnt_nxt       = NB_CNT;
                  w_grant_alu_nxt = 1'b1;
               end else begin
                  w_rf_ack        = 1'b1;
                  w_hold_nxt      = w_rf_ext;
                  w_cnt_nxt       = CW'(1);
                  w_grant_alu_nxt = 1'b0;
               end
            end
         end
         S_LOAD: begin
            w_to_nxt    = '0;
            w_state_nxt = S_WAIT_START;
         end
         S_WAIT_START: begin
            // START_TIMEOUT quiet cycles here, then the same byte is strobed again.
            if (i_tx_busy) begin
               w_state_nxt = S_WAIT_END;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_to_nxt = r_to_cnt + TW'(1);
            end
         end
         S_WAIT_END: begin
            if (!i_tx_busy) begin
               w_hold_nxt = r_hold >> DATA_WIDTH;
               w_cnt_nxt  = r_cnt - CW'(1);
               if (w_cnt_nxt != '0) begin
                  w_state_nxt = S_LOAD;
               end else begin
                  w_state_nxt      = S_IDLE;
                  w_last_alu_nxt   = r_grant_alu;
                  w_sched_busy_nxt = 1'b0;
                  w_grant_alu_nxt  = 1'b0;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_hold       <= '0;
         r_cnt        <= '0;
         r_to_cnt     <= '0;
         r_last_alu   <= 1'b0;
         r_sched_busy <= 1'b0;
         r_grant_alu  <= 1'b0;
         r_tx_p_data  <= '0;
         r_tx_dv      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_hold       <= w_hold_nxt;
         r_cnt        <= w_cnt_nxt;
         r_to_cnt     <= w_to_nxt;
         r_last_alu   <= w_last_alu_nxt;
         r_sched_busy <= w_sched_busy_nxt;
         r_grant_alu  <= w_grant_alu_nxt;
         // The strobe and its byte are registered on entry to LOAD so they appear during LOAD.
         r_tx_dv      <= (w_state_nxt == S_LOAD);
         if (w_state_nxt == S_LOAD) begin
            r_tx_p_data <= w_hold_nxt[DATA_WIDTH-1:0];
         end
      end
   end

   // ACK is combinational in the granting cycle; masked so that all outputs read 0 under reset.
   assign o_alu_ack       = w_alu_ack & ~i_rst;
   assign o_rf_ack        = w_rf_ack & ~i_rst;
   assign o_tx_p_data     = r_tx_p_data;
   assign o_tx_data_valid = r_tx_dv;
   assign o_sched_busy    = r_sched_busy;
   assign o_grant_alu     = r_grant_alu;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Purpose : self-checking bench for uart_tx_scheduler with a behavioural UART transmitter.
// Latency : table vectors, hand-written corner sequences, then randomized requesters against a scoreboard.
// Backpr. : the transmitter model raises Busy one cycle after a strobe and can ignore strobes.
module tb_uart_tx_scheduler;

   localparam int DW = 8;
   localparam int AW = 16;
   localparam int TO = 4;
   localparam int NB = AW / DW;
   localparam int NV = 9;
   localparam int NREQ = 25;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_vld, rf_vld, tx_busy;
   logic [AW-1:0] alu_out;
   logic [DW-1:0] rf_data;
   logic          alu_ack, rf_ack, tx_dv, sched_busy, grant_alu;
   logic [DW-1:0] tx_p_data;

   uart_tx_scheduler #(.DATA_WIDTH(DW), .ALU_WIDTH(AW), .START_TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_alu_vld(alu_vld), .i_alu_out(alu_out), .o_alu_ack(alu_ack),
      .i_rf_vld(rf_vld), .i_rf_data(rf_data), .o_rf_ack(rf_ack),
      .i_tx_busy(tx_busy), .o_tx_p_data(tx_p_data), .o_tx_data_valid(tx_dv),
      .o_sched_busy(sched_busy), .o_grant_alu(grant_alu)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- transmitter model + strobe log ----------------
   logic          tx_auto = 1'b1;
   logic          tx_pend = 1'b0;
   int            tx_rem = 0;
   int            tx_ignore = 0;
   int            cyc = 0;
   int            viol_dv = 0;
   int            viol_ack = 0;
   logic          sb_on = 1'b0;
   logic [DW-1:0] log_b[$];
   int            log_c[$];
   logic [8:0]    exp_q[$];   // {is_alu, byte}

   initial begin
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (tx_auto) begin
            if (tx_rem > 0) begin
               tx_rem--;
               if (tx_rem == 0) tx_busy = 1'b0;
            end
            if (tx_pend) begin
               tx_busy = 1'b1;
               tx_rem  = sb_on ? $urandom_range(1, 12) : 11;
               tx_pend = 1'b0;
            end
         end
         if (tx_dv) begin
            if (tx_busy) viol_dv++;
            log_b.push_back(tx_p_data);
            log_c.push_back(cyc);
            if (sb_on) begin
               logic [8:0] e;
               e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'bx;
               chk("sb_byte", {grant_alu, tx_p_data}, e);
            end
            if (tx_auto) begin
               if (tx_ignore > 0) tx_ignore--;
               else tx_pend = 1'b1;
            end
         end
      end
   end

   // ---------------- ACK monitor + reference arbitration model ----------------
   int   alu_ack_cnt = 0;
   int   rf_ack_cnt = 0;
   logic m_last_alu = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (alu_ack) alu_ack_cnt++;
         if (rf_ack) rf_ack_cnt++;
         if ((alu_ack || rf_ack) && sched_busy) viol_ack++;
         if (alu_ack && rf_ack) viol_ack++;
         if (sb_on && (alu_ack || rf_ack)) begin
            if (alu_vld && rf_vld) chk("rr_winner", alu_ack, !m_last_alu);
            if (alu_ack) begin
               for (int k = 0; k < NB; k++) exp_q.push_back({1'b1, alu_out[k*DW +: DW]});
               m_last_alu = 1'b1;
            end else begin
               exp_q.push_back({1'b0, rf_data});
               m_last_alu = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   // Waits until n strobes in total are logged and the transmitter is idle again.
   task automatic wait_done(input int n);
      int t = 0;
      while (!(log_b.size() >= n && !tx_busy && !tx_pend && tx_rem == 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("xfer_done_in_time", (t < 300), 1'b1);
   endtask

   typedef struct {
      logic          a_vld;
      logic          r_vld;
      logic [AW-1:0] a_dat;
      logic [DW-1:0] r_dat;
      logic          g_alu;
      int            nb;
      logic [DW-1:0] b0;
      logic [DW-1:0] b1;
   } vec_t;

   vec_t V[NV];

   initial begin
      int s0, a0, r0, t;
      logic [1:0] got;
      logic blocked;

      V[0] = '{1'b1, 1'b1, 16'hA55A, 8'h3C, 1'b1, 2, 8'h5A, 8'hA5};  // tie after reset -> ALU
      V[1] = '{1'b0, 1'b1, 16'h0000, 8'h3C, 1'b0, 1, 8'h3C, 8'h00};  // waiting RF served
      V[2] = '{1'b1, 1'b1, 16'h1234, 8'h77, 1'b1, 2, 8'h34, 8'h12};  // tie, RF last -> ALU
      V[3] = '{1'b1, 1'b1, 16'hBEEF, 8'h77, 1'b0, 1, 8'h77, 8'h00};  // tie, ALU last -> RF
      V[4] = '{1'b1, 1'b1, 16'hBEEF, 8'hC3, 1'b1, 2, 8'hEF, 8'hBE};  // tie, RF last -> ALU
      V[5] = '{1'b0, 1'b1, 16'h0000, 8'hC3, 1'b0, 1, 8'hC3, 8'h00};
      V[6] = '{1'b1, 1'b0, 16'h0F0F, 8'h00, 1'b1, 2, 8'h0F, 8'h0F};
      V[7] = '{1'b1, 1'b1, 16'h8001, 8'h99, 1'b0, 1, 8'h99, 8'h00};  // tie, ALU last -> RF
      V[8] = '{1'b1, 1'b0, 16'h8001, 8'h00, 1'b1, 2, 8'h01, 8'h80};

      rst = 1'b1; alu_vld = 1'b0; rf_vld = 1'b0; alu_out = '0; rf_data = '0; tx_busy = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {alu_ack, rf_ack, tx_dv, sched_busy, grant_alu, tx_p_data}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---------------- table-driven transfers ----------------
      for (int i = 0; i < NV; i++) begin
         alu_vld = V[i].a_vld;
         if (V[i].a_vld) alu_out = V[i].a_dat;
         rf_vld = V[i].r_vld;
         if (V[i].r_vld) rf_data = V[i].r_dat;
         s0 = log_b.size();
         @(negedge clk);
         chk($sformatf("v%0d_idle", i), sched_busy, 1'b0);
         got = {alu_ack, rf_ack};
         chk($sformatf("v%0d_ack", i), got, V[i].g_alu ? 2'b10 : 2'b01);
         @(posedge clk); #1;
         if (got[1]) alu_vld = 1'b0;
         if (got[0]) rf_vld = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_load", i), {tx_dv, sched_busy, grant_alu, tx_p_data},
             {1'b1, 1'b1, V[i].g_alu, V[i].b0});
         wait_done(s0 + V[i].nb);
         chk($sformatf("v%0d_nbytes", i), log_b.size() - s0, V[i].nb);
         chk($sformatf("v%0d_b0", i), log_b[s0], V[i].b0);
         if (V[i].nb == 2) chk($sformatf("v%0d_b1", i), log_b[s0+1], V[i].b1);
         chk($sformatf("v%0d_hold", i), {sched_busy, tx_p_data},
             {1'b1, (V[i].nb == 2) ? V[i].b1 : V[i].b0});
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("table_final_idle", sched_busy, 1'b0);
      @(posedge clk); #1;

      // ---------------- ignored strobe -> re-strobe after timeout ----------------
      tx_ignore = 1;
      alu_vld = 1'b1; alu_out = 16'hC001;
      s0 = log_b.size(); a0 = alu_ack_cnt;
      @(negedge clk);
      chk("retry_ack", alu_ack, 1'b1);
      @(posedge clk); #1;
      alu_vld = 1'b0;
      wait_done(s0 + 3);
      chk("retry_nstrobes", log_b.size() - s0, 3);
      chk("retry_bytes", {log_b[s0], log_b[s0+1], log_b[s0+2]}, 24'h0101C0);
      chk("retry_gap", log_c[s0+1] - log_c[s0], TO + 1);
      @(posedge clk); #1;
      chk("retry_single_ack", alu_ack_cnt - a0, 1);
      repeat (2) @(posedge clk);
      #1;

      // ---------------- TX_BUSY held high at IDLE ----------------
      tx_auto = 1'b0; tx_busy = 1'b1;
      rf_vld = 1'b1; rf_data = 8'h66;
      s0 = log_b.size();
      blocked = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rf_ack || tx_dv) blocked = 1'b1;
      end
      chk("busy_blocks_grant", {blocked, sched_busy}, 2'b00);
      @(posedge clk); #1;
      tx_busy = 1'b0; tx_auto = 1'b1;
      @(negedge clk);
      chk("busy_release_ack", {rf_ack, tx_dv}, 2'b10);
      @(posedge clk); #1;
      rf_vld = 1'b0;
      @(negedge clk);
      chk("busy_release_strobe", {tx_dv, grant_alu, tx_p_data}, {1'b1, 1'b0, 8'h66});
      wait_done(s0 + 1);
      @(posedge clk); #1;
      @(posedge clk); #1;

      // ---------------- reset during the second ALU byte ----------------
      alu_vld = 1'b1; alu_out = 16'hA55A;
      s0 = log_b.size();
      @(negedge clk);
      chk("rst_seq_ack", alu_ack, 1'b1);
      @(posedge clk); #1;
      alu_vld = 1'b0; rf_vld = 1'b1; rf_data = 8'hE7;
      t = 0;
      while (log_b.size() - s0 < 2 && t < 100) begin @(negedge clk); t++; end
      chk("rst_seq_second_byte", log_b[s0+1], 8'hA5);
      repeat (3) @(negedge clk);
      #1;
      a0 = alu_ack_cnt; r0 = rf_ack_cnt;
      rst = 1'b1;
      #1;
      chk("rst_async_outputs", {alu_ack, rf_ack, tx_dv, sched_busy, grant_alu, tx_p_data}, 0);
      @(negedge clk);
      chk("rst_held_outputs", {rf_ack, tx_dv, sched_busy, grant_alu, tx_p_data}, 0);
      rst = 1'b0;
      s0 = log_b.size();
      t = 0;
      while (!rf_ack && t < 100) begin @(negedge clk); t++; end
      chk("rst_then_rf_ack", {rf_ack, alu_ack}, 2'b10);
      @(posedge clk); #1;
      rf_vld = 1'b0;
      @(negedge clk);
      chk("rst_then_rf_strobe", {tx_dv, grant_alu, tx_p_data}, {1'b1, 1'b0, 8'hE7});
      wait_done(s0 + 1);
      @(posedge clk); #1;
      chk("rst_no_alu_reack", alu_ack_cnt - a0, 0);
      chk("rst_rf_one_ack", rf_ack_cnt - r0, 1);

      // ---------------- randomized requesters vs scoreboard ----------------
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_last_alu = 1'b0;
      exp_q.delete();
      sb_on = 1'b1;
      fork
         begin : alu_req
            int ta;
            for (int n = 0; n < NREQ; n++) begin
               repeat ($urandom_range(0, 15)) @(posedge clk);
               @(posedge clk); #1;
               alu_out = AW'($urandom);
               alu_vld = 1'b1;
               ta = 0;
               do begin @(negedge clk); ta++; end while (!alu_ack && ta < 3000);
               chk("rand_alu_ack_in_time", (ta < 3000), 1'b1);
               @(posedge clk); #1;
               alu_vld = 1'b0;
            end
         end
         begin : rf_req
            int tr;
            for (int n = 0; n < NREQ; n++) begin
               repeat ($urandom_range(0, 15)) @(posedge clk);
               @(posedge clk); #1;
               rf_data = DW'($urandom);
               rf_vld = 1'b1;
               tr = 0;
               do begin @(negedge clk); tr++; end while (!rf_ack && tr < 3000);
               chk("rand_rf_ack_in_time", (tr < 3000), 1'b1);
               @(posedge clk); #1;
               rf_vld = 1'b0;
            end
         end
      join
      t = 0;
      while ((exp_q.size() != 0 || sched_busy || tx_busy || tx_pend) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("rand_drain", exp_q.size(), 0);
      sb_on = 1'b0;

      chk("no_ack_while_busy", viol_ack, 0);
      chk("no_strobe_while_tx_busy", viol_dv, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
